// File: rtl/matrix_result_streamer_pkg.sv
// Shared constants, dimension-code helpers and stream state for the result streamer.
package matrix_result_streamer_pkg;

    localparam int unsigned ELEM_W     = 16;
    localparam int unsigned MAX_DIM    = 5;
    localparam int unsigned DIM_W      = 3;
    localparam int unsigned NUM_ELEM   = MAX_DIM * MAX_DIM;
    localparam int unsigned RES_W      = NUM_ELEM * ELEM_W;
    localparam int unsigned DIM_CODE_W = 2 * DIM_W;
    // Flat element index width; MAX_DIM*MAX_DIM-1 = 24 fits in 5 bits.
    localparam int unsigned IDX_W      = 5;

    localparam logic [DIM_W-1:0] MAX_DIM_V = DIM_W'(MAX_DIM);

    typedef enum logic {
        StIdle   = 1'b0,
        StStream = 1'b1
    } stream_state_e;

    // Dimension code layout: {rows, cols}.
    function automatic logic [DIM_W-1:0] rows_of(input logic [DIM_CODE_W-1:0] dim);
        return dim[DIM_CODE_W-1 -: DIM_W];
    endfunction

    function automatic logic [DIM_W-1:0] cols_of(input logic [DIM_CODE_W-1:0] dim);
        return dim[DIM_W-1:0];
    endfunction

    // Row-major flat index row*cols+col, evaluated at IDX_W bits.
    function automatic logic [IDX_W-1:0] elem_idx(input logic [DIM_W-1:0] row,
                                                   input logic [DIM_W-1:0] col,
                                                   input logic [DIM_W-1:0] cols);
        return IDX_W'(row) * IDX_W'(cols) + IDX_W'(col);
    endfunction

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Element stream toward the output formatter: one element per valid/ready beat.
interface matrix_result_streamer_if;
    import matrix_result_streamer_pkg::*;

    logic              valid;
    logic              ready;
    logic [ELEM_W-1:0] data;
    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  col;
    logic              eol;
    logic              last;

    modport master (
        output valid, data, row, col, eol, last,
        input  ready
    );

    modport slave (
        input  valid, data, row, col, eol, last,
        output ready
    );

endinterface

// File: rtl/matrix_result_streamer.sv
// Captures a completed matrix result and streams its elements row-major, one per handshake.
module matrix_result_streamer
    import matrix_result_streamer_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_res_valid,
    input  logic                        i_res_error,
    input  logic [RES_W-1:0]            i_result_data,
    input  logic [DIM_CODE_W-1:0]       i_result_dim,
    matrix_result_streamer_if.master    m_if,
    output logic                        o_busy,
    output logic                        o_bad_dim,
    output logic                        o_overrun
);

    stream_state_e     r_state, w_state_nxt;

    logic [RES_W-1:0]  r_mat, w_mat_nxt;
    logic [DIM_W-1:0]  r_rows, w_rows_nxt;
    logic [DIM_W-1:0]  r_cols, w_cols_nxt;
    logic [DIM_W-1:0]  r_row, w_row_nxt;
    logic [DIM_W-1:0]  r_col, w_col_nxt;
    logic [ELEM_W-1:0] r_data, w_data_nxt;
    logic              r_eol, w_eol_nxt;
    logic              r_last, w_last_nxt;
    logic              r_active, w_active_nxt;
    logic              r_bad_dim, w_bad_dim_nxt;
    logic              r_overrun, w_overrun_nxt;

    logic [DIM_W-1:0]  w_rows_in, w_cols_in;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_dim_ok, w_take, w_xfer;

    assign w_rows_in = rows_of(i_result_dim);
    assign w_cols_in = cols_of(i_result_dim);
    assign w_dim_ok  = (w_rows_in != '0) && (w_cols_in != '0) &&
                       (w_rows_in <= MAX_DIM_V) && (w_cols_in <= MAX_DIM_V);
    assign w_take    = i_res_valid && !i_res_error;
    assign w_xfer    = r_active && m_if.ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start on a clean, in-range result; finish on the m_last transfer.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (w_take && w_dim_ok) w_state_nxt = StStream;
            StStream: if (w_xfer && r_last)   w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    // Next values of the latched result and of every registered output.
    always_comb begin
        w_mat_nxt     = r_mat;
        w_rows_nxt    = r_rows;
        w_cols_nxt    = r_cols;
        w_row_nxt     = r_row;
        w_col_nxt     = r_col;
        w_data_nxt    = r_data;
        w_eol_nxt     = r_eol;
        w_last_nxt    = r_last;
        w_active_nxt  = r_active;
        w_bad_dim_nxt = 1'b0;
        w_overrun_nxt = 1'b0;
        w_idx_nxt     = '0;
        unique case (r_state)
            StIdle: begin
                if (w_take && !w_dim_ok) begin
                    w_bad_dim_nxt = 1'b1;
                end else if (w_take) begin
                    // Element 0 comes straight from the bus; the latch is not loaded yet.
                    w_mat_nxt    = i_result_data;
                    w_rows_nxt   = w_rows_in;
                    w_cols_nxt   = w_cols_in;
                    w_row_nxt    = '0;
                    w_col_nxt    = '0;
                    w_data_nxt   = i_result_data[ELEM_W-1:0];
                    w_eol_nxt    = (w_cols_in == DIM_W'(1));
                    w_last_nxt   = (w_cols_in == DIM_W'(1)) && (w_rows_in == DIM_W'(1));
                    w_active_nxt = 1'b1;
                end
            end
            StStream: begin
                // Any result arriving mid-stream is dropped, error flag or not.
                w_overrun_nxt = i_res_valid;
                if (w_xfer && r_last) begin
                    w_row_nxt    = '0;
                    w_col_nxt    = '0;
                    w_data_nxt   = '0;
                    w_eol_nxt    = 1'b0;
                    w_last_nxt   = 1'b0;
                    w_active_nxt = 1'b0;
                end else if (w_xfer) begin
                    if (r_eol) begin
                        w_row_nxt = r_row + DIM_W'(1);
                        w_col_nxt = '0;
                    end else begin
                        w_col_nxt = r_col + DIM_W'(1);
                    end
                    w_idx_nxt  = elem_idx(w_row_nxt, w_col_nxt, r_cols);
                    w_data_nxt = r_mat[w_idx_nxt * ELEM_W +: ELEM_W];
                    w_eol_nxt  = (w_col_nxt == r_cols - DIM_W'(1));
                    w_last_nxt = (w_col_nxt == r_cols - DIM_W'(1)) &&
                                 (w_row_nxt == r_rows - DIM_W'(1));
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; everything clears asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mat     <= '0;
            r_rows    <= '0;
            r_cols    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_data    <= '0;
            r_eol     <= 1'b0;
            r_last    <= 1'b0;
            r_active  <= 1'b0;
            r_bad_dim <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_mat     <= w_mat_nxt;
            r_rows    <= w_rows_nxt;
            r_cols    <= w_cols_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_data    <= w_data_nxt;
            r_eol     <= w_eol_nxt;
            r_last    <= w_last_nxt;
            r_active  <= w_active_nxt;
            r_bad_dim <= w_bad_dim_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign m_if.valid = r_active;
    assign m_if.data  = r_data;
    assign m_if.row   = r_row;
    assign m_if.col   = r_col;
    assign m_if.eol   = r_eol;
    assign m_if.last  = r_last;
    assign o_busy     = r_active;
    assign o_bad_dim  = r_bad_dim;
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench: expected beats are queued when a result is driven and checked as they stream out.
module tb_matrix_result_streamer;
    import matrix_result_streamer_pkg::*;

    typedef struct packed {
        logic [ELEM_W-1:0] data;
        logic [DIM_W-1:0]  row;
        logic [DIM_W-1:0]  col;
        logic              eol;
        logic              last;
    } beat_t;

    logic                  clk;
    logic                  rst_n;
    logic                  i_res_valid;
    logic                  i_res_error;
    logic [RES_W-1:0]      i_result_data;
    logic [DIM_CODE_W-1:0] i_result_dim;
    logic                  o_busy;
    logic                  o_bad_dim;
    logic                  o_overrun;

    matrix_result_streamer_if m_if ();

    matrix_result_streamer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_res_valid   (i_res_valid),
        .i_res_error   (i_res_error),
        .i_result_data (i_result_data),
        .i_result_dim  (i_result_dim),
        .m_if          (m_if.master),
        .o_busy        (o_busy),
        .o_bad_dim     (o_bad_dim),
        .o_overrun     (o_overrun)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   m_if.valid, 0);
        check({tag, "_data"},    m_if.data,  0);
        check({tag, "_row"},     m_if.row,   0);
        check({tag, "_col"},     m_if.col,   0);
        check({tag, "_eol"},     m_if.eol,   0);
        check({tag, "_last"},    m_if.last,  0);
        check({tag, "_busy"},    o_busy,     0);
        check({tag, "_bad_dim"}, o_bad_dim,  0);
        check({tag, "_overrun"}, o_overrun,  0);
    endtask

    task automatic push_matrix(input logic [RES_W-1:0] d, input int rows, input int cols);
        beat_t b;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                b.data = d[(r * cols + c) * ELEM_W +: ELEM_W];
                b.row  = DIM_W'(r);
                b.col  = DIM_W'(c);
                b.eol  = (c == cols - 1);
                b.last = (c == cols - 1) && (r == rows - 1);
                sb.push_back(b);
            end
        end
    endtask

    // Called at posedge+1; holds res_valid for one cycle, then scrambles the bus.
    task automatic drive_result(input logic [RES_W-1:0] d, input int rows, input int cols,
                                input logic err);
        i_result_data = d;
        i_result_dim  = {DIM_W'(rows), DIM_W'(cols)};
        i_res_error   = err;
        i_res_valid   = 1'b1;
        @(posedge clk);
        #1;
        i_res_valid   = 1'b0;
        i_res_error   = 1'b0;
        i_result_data = {NUM_ELEM{16'hBAD0}};
        i_result_dim  = '1;
    endtask

    task automatic drive_reject(input string tag, input int rows, input int cols,
                                input logic err, input logic exp_bad);
        drive_result('0, rows, cols, err);
        @(negedge clk);
        check({tag, "_bad_dim"}, o_bad_dim, exp_bad);
        check({tag, "_valid"},   m_if.valid, 0);
        check({tag, "_overrun"}, o_overrun, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_bad_dim_clear"}, o_bad_dim, 0);
        check({tag, "_valid_idle"},    m_if.valid, 0);
        @(posedge clk);
        #1;
    endtask

    // Per-cycle stream checker. Bit k of rdy_pat is m_ready in cycle k; inj_a/inj_b are
    // cycles where a stray result is injected. stop_at >= 0 ends the run early on purpose.
    task automatic run_stream(input string tag, input logic [31:0] rdy_pat, input int inj_a,
                              input int inj_b, input int stop_at);
        logic  exp_over;
        logic  inj;
        logic  seen_empty;
        beat_t ob;
        int    k;
        exp_over = 1'b0;
        k        = 0;
        forever begin
            m_ready_drive((k < 32) ? rdy_pat[k] : 1'b1);
            inj = (k == inj_a) || (k == inj_b);
            if (inj) begin
                i_res_valid   = 1'b1;
                i_res_error   = (k == inj_b);
                i_result_data = {NUM_ELEM{16'h5A5A}};
                i_result_dim  = {DIM_W'(1), DIM_W'(1)};
            end
            @(negedge clk);
            seen_empty = (sb.size() == 0);
            check({tag, "_valid"},   m_if.valid, !seen_empty);
            check({tag, "_busy"},    o_busy,     !seen_empty);
            check({tag, "_overrun"}, o_overrun,  exp_over);
            check({tag, "_bad_dim"}, o_bad_dim,  0);
            if (m_if.valid && !seen_empty) begin
                ob.data = m_if.data;
                ob.row  = m_if.row;
                ob.col  = m_if.col;
                ob.eol  = m_if.eol;
                ob.last = m_if.last;
                check({tag, "_beat"}, ob, sb[0]);
                if (m_if.ready) void'(sb.pop_front());
            end
            exp_over = inj;
            @(posedge clk);
            #1;
            i_res_valid = 1'b0;
            i_res_error = 1'b0;
            k++;
            if (stop_at >= 0 && k >= stop_at) break;
            if (seen_empty && !inj) break;
            if (k > 100) begin
                check({tag, "_timeout_pending"}, sb.size(), 0);
                sb.delete();
                break;
            end
        end
    endtask

    task automatic m_ready_drive(input logic v);
        m_if.ready = v;
    endtask

    logic [RES_W-1:0] mat;

    initial begin
        rst_n         = 1'b0;
        i_res_valid   = 1'b0;
        i_res_error   = 1'b0;
        i_result_data = '0;
        i_result_dim  = '0;
        m_if.ready    = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2x3, elements 1..6, always ready.
        mat = '0;
        for (int i = 0; i < 6; i++) mat[i * ELEM_W +: ELEM_W] = ELEM_W'(i + 1);
        push_matrix(mat, 2, 3);
        drive_result(mat, 2, 3, 1'b0);
        run_stream("m2x3", '1, -1, -1, -1);

        // Same result with stalls: ready 1,0,0,1,0,1,1,1 then held high.
        push_matrix(mat, 2, 3);
        drive_result(mat, 2, 3, 1'b0);
        run_stream("m2x3_stall", 32'hFFFF_FFE9, -1, -1, -1);

        // Dimension rejects and an error-flagged result.
        drive_reject("rej_rows0", 0, 3, 1'b0, 1'b1);
        drive_reject("rej_cols0", 3, 0, 1'b0, 1'b1);
        drive_reject("rej_rows6", 6, 2, 1'b0, 1'b1);
        drive_reject("err_flag",  2, 3, 1'b1, 1'b0);

        // 5x5 full-size, last element 16'hFFFF at (4,4).
        mat = '0;
        for (int i = 0; i < 25; i++) mat[i * ELEM_W +: ELEM_W] = ELEM_W'(i);
        mat[24 * ELEM_W +: ELEM_W] = 16'hFFFF;
        push_matrix(mat, 5, 5);
        drive_result(mat, 5, 5, 1'b0);
        run_stream("m5x5", '1, -1, -1, -1);

        // 3x3 with stray results at beat 2 and in the final-transfer cycle.
        mat = '0;
        for (int i = 0; i < 9; i++) mat[i * ELEM_W +: ELEM_W] = ELEM_W'(16'h0100 + i);
        push_matrix(mat, 3, 3);
        drive_result(mat, 3, 3, 1'b0);
        run_stream("m3x3_ovr", '1, 1, 8, -1);
        @(negedge clk);
        check("m3x3_ovr_idle_valid",   m_if.valid, 0);
        check("m3x3_ovr_idle_overrun", o_overrun,  0);
        @(posedge clk);
        #1;

        // 4x4 aborted by reset after four beats.
        mat = '0;
        for (int i = 0; i < 16; i++) mat[i * ELEM_W +: ELEM_W] = ELEM_W'(16'h1000 + i);
        push_matrix(mat, 4, 4);
        drive_result(mat, 4, 4, 1'b0);
        run_stream("m4x4", '1, -1, -1, 4);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_post_valid", m_if.valid, 0);
        @(posedge clk);
        #1;

        // 1x1 after reset.
        mat = '0;
        mat[ELEM_W-1:0] = 16'h00AB;
        push_matrix(mat, 1, 1);
        drive_result(mat, 1, 1, 1'b0);
        run_stream("m1x1", '1, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matrix_result_streamer.md
# matrix_result_streamer

Downstream stage of the matrix calculator. Captures one completed result (400-bit packed bus plus 6-bit dimension code) when the calculator pulses done, then streams the elements in row-major order, one 16-bit element per valid/ready handshake, toward the output path (UART/display formatter). Each beat is tagged with row/column position, end-of-row and last-element markers. Dimension codes that are empty or out of range are rejected, and results arriving while a stream is in progress are flagged.

## Interface
Parameters:
- ELEM_W, 16, element width in bits.
- MAX_DIM, 5, maximum rows/columns.
- DIM_W, 3, width of each dimension field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- res_valid  in  1  single-cycle result-ready pulse (calculator done).
- res_error  in  1  calculator error flag, sampled with res_valid.
- result_data  in  400  packed result; element i at [i*16 +: 16].
- result_dim  in  6  {rows[5:3], cols[2:0]}.
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream ready.
- m_data  out  ELEM_W  current element.
- m_row  out  DIM_W  row index of current element.
- m_col  out  DIM_W  column index of current element.
- m_eol  out  1  current element is the last of its row.
- m_last  out  1  current element is the last of the matrix.
- busy  out  1  high in STREAM.
- bad_dim  out  1  one-cycle pulse: a result was rejected for its dimension code.
- overrun  out  1  one-cycle pulse: a result arrived while busy and was dropped.

## Operation
- States: IDLE, STREAM.
- IDLE, res_valid=1, res_error=1:
  - The result is ignored. No pulse is raised.
- IDLE, res_valid=1, res_error=0:
  - rows or cols equal to 0, or greater than MAX_DIM: bad_dim pulses and the block stays in IDLE.
  - Otherwise: latch result_data, rows and cols; set r=0, c=0; go to STREAM.
- STREAM:
  - m_valid=1; m_data = latched[(r*cols+c)*16 +: 16]; m_row=r; m_col=c.
  - m_eol = (c==cols-1); m_last = m_eol && (r==rows-1).
- Handshake:
  - A beat transfers when m_valid && m_ready.
  - On transfer: c increments; at c==cols-1, c wraps to 0 and r increments.
  - A transfer with m_last set returns the block to IDLE.
- Any res_valid while in STREAM, including the cycle of the final transfer: pulse overrun (regardless of res_error), drop the input, and leave the stream unaffected.
- Index arithmetic: r*cols+c is computed at 5 bits, maximum 24. Elements at or beyond rows*cols are never emitted.
- Only the latched copy is used. result_data may change freely after capture.

## Timing
- Reset value of every output is 0, applied asynchronously. Internal state resets to IDLE with r=c=0.
- Reset mid-stream aborts the stream: m_valid drops immediately and no further beats occur after release.
- All outputs are registered.
- Latency: res_valid at cycle N gives m_valid=1 with element 0 at cycle N+1.
- Throughput: one element per cycle while m_ready=1. An R×C matrix occupies cycles N+1..N+R*C.
- m_valid falls in the cycle after the m_last transfer. The earliest next accepted res_valid is that cycle.
- While m_valid=1 && m_ready=0: m_data, m_row, m_col, m_eol and m_last hold stable, and m_valid does not drop.
- bad_dim and overrun are asserted in the cycle after the offending res_valid, for exactly one cycle.

## Structure
- Shared package holds:
  - ELEM_W, MAX_DIM, DIM_W.
  - Dimension-field extraction functions (rows_of, cols_of).
  - Stream state enum {IDLE, STREAM}, shared with the upstream calculator's result-bus constants.
- Single module. No sub-module is warranted: the r/c counter and the element mux are small enough to stay inline.

## Test plan
- 2×3 result, elements 1..6, m_ready held 1 → 6 beats carrying data 1..6 on cycles N+1..N+6.
  - Positions: (0,0)…(1,2); m_eol on beats 3 and 6; m_last on beat 6 only.
  - busy falls at N+7.
- Same 2×3 result with m_ready pattern 1,0,0,1,0,1,1,1 → all outputs stable during stalls, same 6 values in order, no duplicated or skipped beats.
- Dimension rejects: result_dim=6'b000_011, 6'b011_000 and 6'b110_010 → bad_dim pulses once each, m_valid stays 0.
  - res_valid with res_error=1 and a valid dim → no output and no pulse.
- 5×5 result, element i = i, element 24 = 16'hFFFF → 25 beats; the last beat carries 16'hFFFF at (4,4) with m_last=1.
- 3×3 stream in progress; res_valid pulsed at beat 2 and again in the final-transfer cycle → two overrun pulses, the original 9 values complete unchanged, and the block returns to IDLE with no new stream.
- Reset asserted at beat 4 of a 4×4 stream → all outputs 0 immediately. After release, a new 1×1 result with value 16'h00AB streams as a single beat with m_eol=m_last=1.
